// File: rtl/tlul_addr_mux_pkg.sv
// ---------------------------------------------------------------------------
// | Module  : tlul_addr_mux_pkg                                               |
// | Brief   : Decode and error-response helpers for the TL-UL address mux     |
// | Revision: 1.0                                                             |
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

package tlul_addr_mux_pkg;

  // Window index of an address; anything past the last device maps to the
  // error responder, which sits at pseudo-index num.
  function automatic logic [31:0] dev_sel(input logic [31:0] addr,
                                          input int unsigned shift,
                                          input int unsigned num);
    logic [31:0] idx;
    idx = addr >> shift;
    return (idx < num) ? idx : 32'(num);
  endfunction

  // Reads get data-carrying acks, writes get plain acks.
  function automatic tlul_pkg::tl_d_op_e err_rsp_opcode(input tlul_pkg::tl_a_op_e op);
    return (op == tlul_pkg::Get) ? tlul_pkg::AccessAckData : tlul_pkg::AccessAck;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tlul_pkg.sv
// ---------------------------------------------------------------------------
// | Module  : tlul_pkg                                                        |
// | Brief   : TL-UL channel structures and opcode enumerations                |
// | Revision: 1.0                                                             |
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

package tlul_pkg;

  localparam int TL_AW  = 32;
  localparam int TL_DW  = 32;
  localparam int TL_AIW = 8;
  localparam int TL_DIW = 1;
  localparam int TL_SZW = 2;
  localparam int TL_DBW = TL_DW / 8;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic              a_valid;
    tl_a_op_e          a_opcode;
    logic [2:0]        a_param;
    logic [TL_SZW-1:0] a_size;
    logic [TL_AIW-1:0] a_source;
    logic [TL_AW-1:0]  a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0]  a_data;
    logic              d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic              d_valid;
    tl_d_op_e          d_opcode;
    logic [2:0]        d_param;
    logic [TL_SZW-1:0] d_size;
    logic [TL_AIW-1:0] d_source;
    logic [TL_DIW-1:0] d_sink;
    logic [TL_DW-1:0]  d_data;
    logic              d_error;
    logic              a_ready;
  } tl_d2h_t;

endpackage

`default_nettype wire

// File: rtl/tlul_mux_idx_fifo.sv
// ---------------------------------------------------------------------------
// | Module  : tlul_mux_idx_fifo                                               |
// | Brief   : Small FIFO holding the target index of each outstanding request |
// | Revision: 1.0                                                             |
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tlul_mux_idx_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  // A one-bit pointer is kept even for DEPTH=1 so the storage index is never
  // zero width; the extra entry is simply never addressed.
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [2**PTR_W];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

`default_nettype wire

// File: rtl/tlul_addr_mux.sv
// ---------------------------------------------------------------------------
// | Module  : tlul_addr_mux                                                   |
// | Brief   : TL-UL 1-to-NUM address-decoded mux with in-order responses      |
// |           and an internal error responder for unmapped windows            |
// | Revision: 1.0                                                             |
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tlul_addr_mux
  import tlul_pkg::*;
  import tlul_addr_mux_pkg::*;
#(
  parameter int NUM             = 2,
  parameter int ADDR_SHIFT      = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  tl_h2d_t tl_host_i,
  output tl_d2h_t tl_host_o,
  output tl_h2d_t tl_device_o [NUM],
  input  tl_d2h_t tl_device_i [NUM]
);

  localparam int IDX_W = $clog2(NUM + 1);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [IDX_W-1:0] ERR_IDX = IDX_W'(NUM);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  logic [IDX_W-1:0]  sel;
  logic [IDX_W-1:0]  last_sel;
  logic [IDX_W-1:0]  head;
  logic [CNT_W-1:0]  cnt;
  logic [NUM:0]      tgt_ready_vec;
  logic              tgt_ready;
  logic              stall;
  logic              host_a_ready;
  logic              accept;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  tl_d2h_t           host_rsp;

  logic              err_valid;
  logic [TL_AIW-1:0] err_source;
  logic [TL_SZW-1:0] err_size;
  tl_a_op_e          err_opcode;

  assign sel = IDX_W'(dev_sel(tl_host_i.a_address, ADDR_SHIFT, NUM));

  // Ready of every possible target, error responder in the top slot.
  always_comb begin
    tgt_ready_vec = '0;
    for (int i = 0; i < NUM; i++) tgt_ready_vec[i] = tl_device_i[i].a_ready;
    tgt_ready_vec[NUM] = ~err_valid;
  end

  assign tgt_ready = tgt_ready_vec[sel];

  // Hold off when the window is full, or when switching target while earlier
  // responses are pending (responses must come back in issue order). The FIFO
  // full flag mirrors the counter and keeps the index store from overflowing.
  assign stall = (cnt == CNT_MAX) || fifo_full || ((cnt != '0) && (sel != last_sel));

  assign host_a_ready = rst_ni & tgt_ready & ~stall;
  assign accept       = tl_host_i.a_valid & host_a_ready;

  // A-channel broadcast with per-device valid, D-ready only to the FIFO head.
  always_comb begin
    for (int i = 0; i < NUM; i++) begin
      tl_device_o[i]         = tl_host_i;
      tl_device_o[i].a_valid = tl_host_i.a_valid & rst_ni & ~stall & (sel == IDX_W'(i));
      tl_device_o[i].d_ready = tl_host_i.d_ready & rst_ni & ~fifo_empty & (head == IDX_W'(i));
    end
  end

  // Host response taken from whichever source owns the oldest request.
  always_comb begin
    host_rsp = '0;
    for (int i = 0; i < NUM; i++) begin
      if (head == IDX_W'(i)) host_rsp = tl_device_i[i];
    end
    if (head == ERR_IDX) begin
      host_rsp.d_valid  = err_valid;
      host_rsp.d_opcode = err_rsp_opcode(err_opcode);
      host_rsp.d_error  = 1'b1;
      host_rsp.d_source = err_source;
      host_rsp.d_size   = err_size;
    end
    host_rsp.d_valid = host_rsp.d_valid & ~fifo_empty;
    host_rsp.a_ready = host_a_ready;
  end

  assign tl_host_o = host_rsp;
  assign pop       = host_rsp.d_valid & tl_host_i.d_ready;

  tlul_mux_idx_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_idx_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (accept),
    .wdata  (sel),
    .pop    (pop),
    .rdata  (head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Outstanding counter and the target of the most recent accepted request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt      <= '0;
      last_sel <= '0;
    end else begin
      if (accept) last_sel <= sel;
      case ({accept, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Single-entry error responder; it refuses new requests until drained.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_valid  <= 1'b0;
      err_source <= '0;
      err_size   <= '0;
      err_opcode <= PutFullData;
    end else if (accept && (sel == ERR_IDX)) begin
      err_valid  <= 1'b1;
      err_source <= tl_host_i.a_source;
      err_size   <= tl_host_i.a_size;
      err_opcode <= tl_host_i.a_opcode;
    end else if (pop && (head == ERR_IDX)) begin
      err_valid  <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: doc/tlul_addr_mux.md
Name: tlul_addr_mux

Overview:
- Parametrised TL-UL 1-to-NUM address-decoded mux, successor to the fixed two-device student mux.
- Sits between a single TL-UL host (core data port or test host) and NUM peripheral windows.
- Adds configurable window size and multiple outstanding transactions with in-order response routing.
- Adds an internal error responder for unmapped addresses.

Parameters:
- NUM, 2, number of device ports (1..16).
- ADDR_SHIFT, 4, log2 of window size in bytes; device index = a_address >> ADDR_SHIFT.
- MAX_OUTSTANDING, 4, maximum accepted but unanswered A requests (1..16).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- tl_host_i  in  tlul_pkg::tl_h2d_t  host request / d_ready.
- tl_host_o  out  tlul_pkg::tl_d2h_t  host response / a_ready.
- tl_device_o  out  tlul_pkg::tl_h2d_t [NUM]  per-device request.
- tl_device_i  in  tlul_pkg::tl_d2h_t [NUM]  per-device response.

Behaviour:
- Decode: sel = a_address >> ADDR_SHIFT.
  - sel < NUM targets device sel.
  - Otherwise targets the error responder (pseudo-index NUM).
- A channel is combinational pass-through (zero latency).
  - Only the selected device sees a_valid = 1; all other A fields are broadcast.
  - Host a_ready = target ready AND NOT stall.
- stall when either holds:
  - cnt == MAX_OUTSTANDING (even if a pop occurs in the same cycle);
  - cnt > 0 AND sel != last_sel, i.e. draining before a device switch to preserve order.
- While stalled, every device a_valid = 0 and host a_ready = 0.
- Accept = host a_valid AND host a_ready. On accept:
  - push sel into the index FIFO;
  - last_sel <= sel.
- cnt width is $clog2(MAX_OUTSTANDING+1). It is +1 on accept, -1 on pop, and unchanged when both happen in the same cycle.
- D channel: the FIFO head selects the source device.
  - Host receives that device's d_* fields.
  - Only the head device gets d_ready = host d_ready.
  - Pop on host d_valid AND d_ready.
  - FIFO empty: host d_valid = 0 and all device d_ready = 0.
- Error responder: single-entry buffer.
  - a_ready = buffer empty.
  - On accept it captures a_source, a_size and a_opcode, and asserts d_valid from the next cycle.
  - Response: d_opcode = AccessAckData for Get, AccessAck for PutFull/PutPartial; d_error = 1; d_data = 0; d_source and d_size echoed.
  - Buffer clears when the response is popped.
- Device d_valid while that device is not at the FIFO head: ignored; that device's d_ready = 0.
- Reset (async assert, mid-transaction included):
  - cnt = 0, FIFO empty, last_sel = 0, error buffer empty.
  - Host d_valid = 0.
  - While rst_ni = 0, all device a_valid = 0 and device d_ready = 0.
  - In-flight device responses are the devices' responsibility; they share the reset.
- After reset, host a_ready follows the decoded target's a_ready.

Decomposition:
- tlul_pkg: existing tl_h2d_t/tl_d2h_t and the opcode enums. No new types.
- Local localparams: IDX_W = $clog2(NUM+1), CNT_W.
- One sub-module, tlul_mux_idx_fifo:
  - synchronous FIFO of IDX_W-bit entries, depth MAX_OUTSTANDING;
  - push/pop/full/empty, same-cycle push+pop allowed;
  - reset async active-low.
- Error responder stays inline.

Test Plan:
- NUM=2, ADDR_SHIFT=4, two register devices; write 1 to 0x04 and 2 to 0x14, read back -> 1 and 2, d_error = 0, no cross-talk.
- Get to 0x40 with source 5 -> AccessAckData, d_error = 1, d_data = 0, d_source = 5, one cycle after accept; a following Get to 0x04 returns the correct data.
- Four Gets to device 0 with host d_ready = 0 -> all four accepted; fifth sees a_ready = 0. Raise d_ready for one beat -> fifth accepted the same cycle the stall drops, responses in issue order.
- Get 0x00 then Get 0x10 back-to-back, device 0 response delayed 5 cycles -> device 1 a_valid stays 0 until device 0 response popped; host sees device 0 data before device 1 data.
- Assert rst_ni with 2 requests outstanding -> host d_valid = 0 immediately; after release cnt = 0; a new write/read to 0x14 completes correctly.
- cnt = 1 on device 1 with a new Get to device 1 accepted in the same cycle the old response pops -> cnt stays 1, next response correct; MAX_OUTSTANDING=1 build -> strictly one transaction at a time.
